// File: rtl/seq_loop_pkg.sv
// seq_loop_pkg: shared types and constants for the sequential-loop observer.
`default_nettype none

package seq_loop_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IN_LOOP = 2'd1,
        DONE    = 2'd2
    } loop_state_e;

    localparam int ERR_NO_ENTRY = 0;
    localparam int ERR_REENTRY  = 1;
    localparam int ERR_UNTERM   = 2;
    localparam int ERR_OVF      = 3;

    // Canonical record layout for consumers using the default counter width.
    localparam int REC_CNT_WIDTH = 32;

    typedef struct packed {
        logic [REC_CNT_WIDTH-1:0] trip;
        logic [REC_CNT_WIDTH-1:0] cycles;
    } loop_rec_t;

endpackage

`default_nettype wire

// File: rtl/seq_loop_rec_slot.sv
// seq_loop_rec_slot: single-entry valid/ready record register with overflow detection.
`default_nettype none

module seq_loop_rec_slot #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_trip,
    input  logic [CNT_WIDTH-1:0] load_cycles,
    input  logic                 ready,
    output logic                 valid,
    output logic [CNT_WIDTH-1:0] trip,
    output logic [CNT_WIDTH-1:0] cycles,
    output logic                 overflow
);

    // A record arriving while the held one is stalled is discarded.
    assign overflow = load && valid && !ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid  <= 1'b0;
            trip   <= '0;
            cycles <= '0;
        end else if (load && !overflow) begin
            valid  <= 1'b1;
            trip   <= load_trip;
            cycles <= load_cycles;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_loop_observer.sv
// seq_loop_observer: tracks loop entry/iteration/exit of an HLS kernel FSM and
// reports one {trip, cycles} record per completed loop execution.
`default_nettype none

module seq_loop_observer
    import seq_loop_pkg::*;
#(
    parameter int FSM_WIDTH = 2,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [FSM_WIDTH-1:0] cur_state,
    input  logic                 pre_states_valid,
    input  logic [FSM_WIDTH-1:0] pre_loop_state0,
    input  logic [1:0]           quit_states_valid,
    input  logic [FSM_WIDTH-1:0] quit_loop_state0,
    input  logic [FSM_WIDTH-1:0] quit_loop_state1,
    input  logic [FSM_WIDTH-1:0] loop_quit_state,
    input  logic [FSM_WIDTH-1:0] iter_start_state,
    input  logic                 one_state_loop,
    input  logic                 one_state_block,
    input  logic                 finish,
    output logic                 loop_active,
    output logic [CNT_WIDTH-1:0] iter_count,
    output logic [CNT_WIDTH-1:0] loop_entries,
    output logic                 rec_valid,
    input  logic                 rec_ready,
    output logic [CNT_WIDTH-1:0] rec_trip,
    output logic [CNT_WIDTH-1:0] rec_cycles,
    output logic [3:0]           err_flags,
    output logic                 done
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    loop_state_e          state;
    loop_state_e          next_state;
    logic [FSM_WIDTH-1:0] prev_state;
    logic                 prev_valid;
    logic [CNT_WIDTH-1:0] cyc;
    logic                 ent;
    logic                 ext;
    logic                 it;
    logic                 start;
    logic                 count;
    logic                 close;
    logic                 abort;
    logic [3:0]           err_set;
    logic                 rec_overflow;

    always_comb begin
        ent = prev_valid && (cur_state == iter_start_state)
              && (!pre_states_valid || (prev_state == pre_loop_state0));
        ext = prev_valid && (cur_state == loop_quit_state)
              && ((quit_states_valid[0] && (prev_state == quit_loop_state0))
               || (quit_states_valid[1] && (prev_state == quit_loop_state1)));
        it  = prev_valid && (cur_state == iter_start_state)
              && (one_state_loop || one_state_block || (prev_state != cur_state));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // finish outranks every loop event in every state.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (finish) next_state = DONE; else if (ent) next_state = IN_LOOP;
            IN_LOOP: if (finish) next_state = DONE; else if (ext) next_state = IDLE;
            DONE:    next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        loop_active = (state == IN_LOOP);
        start       = (state == IDLE) && !finish && ent;
        count       = loop_active && !finish && !ext;
        close       = loop_active && !finish && ext;
        abort       = loop_active && finish;
        err_set                = 4'b0000;
        err_set[ERR_NO_ENTRY]  = (state == IDLE) && !finish && !ent && ext;
        err_set[ERR_REENTRY]   = count && ent && pre_states_valid
                                 && (prev_state != iter_start_state);
        err_set[ERR_UNTERM]    = abort;
        err_set[ERR_OVF]       = rec_overflow;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_state   <= '0;
            prev_valid   <= 1'b0;
            iter_count   <= '0;
            cyc          <= '0;
            loop_entries <= '0;
            err_flags    <= 4'b0000;
            done         <= 1'b0;
        end else begin
            prev_state <= cur_state;
            prev_valid <= 1'b1;
            err_flags  <= err_flags | err_set;
            if (finish) begin
                done <= 1'b1;
            end
            if (start) begin
                iter_count   <= CNT_ONE;
                cyc          <= CNT_ONE;
                loop_entries <= sat_inc(loop_entries);
            end else if (count) begin
                cyc <= sat_inc(cyc);
                if (it) begin
                    iter_count <= sat_inc(iter_count);
                end
            end else if (close || abort) begin
                iter_count <= '0;
                cyc        <= '0;
            end
        end
    end

    seq_loop_rec_slot #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_rec_slot (
        .clock       (clock),
        .reset       (reset),
        .load        (close),
        .load_trip   (iter_count),
        .load_cycles (cyc),
        .ready       (rec_ready),
        .valid       (rec_valid),
        .trip        (rec_trip),
        .cycles      (rec_cycles),
        .overflow    (rec_overflow)
    );

endmodule

`default_nettype wire

// File: tb/tb_seq_loop_observer.sv
// tb_seq_loop_observer: directed and randomized checks of seq_loop_observer.
`default_nettype none

module tb_seq_loop_observer;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  cur_state;
    logic        pre_states_valid;
    logic [2:0]  pre_loop_state0;
    logic [1:0]  quit_states_valid;
    logic [2:0]  quit_loop_state0;
    logic [2:0]  quit_loop_state1;
    logic [2:0]  loop_quit_state;
    logic [2:0]  iter_start_state;
    logic        one_state_loop;
    logic        one_state_block;
    logic        finish;
    logic        loop_active;
    logic [31:0] iter_count;
    logic [31:0] loop_entries;
    logic        rec_valid;
    logic        rec_ready;
    logic [31:0] rec_trip;
    logic [31:0] rec_cycles;
    logic [3:0]  err_flags;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    seq_loop_observer #(.FSM_WIDTH(3), .CNT_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .cur_state(cur_state),
        .pre_states_valid(pre_states_valid), .pre_loop_state0(pre_loop_state0),
        .quit_states_valid(quit_states_valid), .quit_loop_state0(quit_loop_state0),
        .quit_loop_state1(quit_loop_state1), .loop_quit_state(loop_quit_state),
        .iter_start_state(iter_start_state), .one_state_loop(one_state_loop),
        .one_state_block(one_state_block), .finish(finish),
        .loop_active(loop_active), .iter_count(iter_count), .loop_entries(loop_entries),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_trip(rec_trip),
        .rec_cycles(rec_cycles), .err_flags(err_flags), .done(done)
    );

    task automatic step(input logic [2:0] s);
        cur_state = s;
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        cur_state = 3'd0; finish = 1'b0; rec_ready = 1'b1;
        pre_states_valid = 1'b1; pre_loop_state0 = 3'd1;
        quit_states_valid = 2'b01; quit_loop_state0 = 3'd4; quit_loop_state1 = 3'd0;
        loop_quit_state = 3'd5; iter_start_state = 3'd2;
        one_state_loop = 1'b0; one_state_block = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        n_checks++;
        if ({loop_active, iter_count, loop_entries, rec_valid, rec_trip, rec_cycles, err_flags, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: active=%b iter=%0d entries=%0d rv=%b trip=%0d cyc=%0d err=%b done=%b, all must be 0",
                     loop_active, iter_count, loop_entries, rec_valid, rec_trip, rec_cycles, err_flags, done);
        end
        apply_reset();
    endtask

    task automatic test_basic_loop();
        apply_reset();
        step(1); step(2);
        n_checks++;
        if (loop_active !== 1'b1 || iter_count !== 32'd1 || loop_entries !== 32'd1) begin
            n_fail++;
            $display("FAIL basic_entry: active=%b iter=%0d entries=%0d, need 1/1/1", loop_active, iter_count, loop_entries);
        end
        step(3); step(4); step(2); step(3); step(4); step(5);
        n_checks++;
        if (rec_valid !== 1'b1 || rec_trip !== 32'd2 || rec_cycles !== 32'd6 || loop_active !== 1'b0 || err_flags !== 4'b0) begin
            n_fail++;
            $display("FAIL basic_record: rv=%b trip=%0d cyc=%0d active=%b err=%b, need 1/2/6/0/0000",
                     rec_valid, rec_trip, rec_cycles, loop_active, err_flags);
        end
        step(0);
        n_checks++;
        if (rec_valid !== 1'b0 || loop_entries !== 32'd1) begin
            n_fail++;
            $display("FAIL basic_drain: rv=%b entries=%0d, need 0/1", rec_valid, loop_entries);
        end
    endtask

    task automatic test_one_state_loop();
        apply_reset();
        one_state_loop = 1'b1; quit_loop_state0 = 3'd2;
        step(1); step(2); step(2); step(2); step(5);
        n_checks++;
        if (rec_valid !== 1'b1 || rec_trip !== 32'd3 || rec_cycles !== 32'd3) begin
            n_fail++;
            $display("FAIL one_state_loop: rv=%b trip=%0d cyc=%0d, need 1/3/3", rec_valid, rec_trip, rec_cycles);
        end
    endtask

    task automatic test_exit_without_entry();
        apply_reset();
        step(4); step(5); step(0);
        n_checks++;
        if (err_flags !== 4'b0001 || rec_valid !== 1'b0 || loop_active !== 1'b0) begin
            n_fail++;
            $display("FAIL no_entry: err=%b rv=%b active=%b, need 0001/0/0", err_flags, rec_valid, loop_active);
        end
    endtask

    task automatic test_reentry();
        apply_reset();
        step(1); step(2); step(3); step(1); step(2);
        n_checks++;
        if (err_flags !== 4'b0010 || iter_count !== 32'd2 || loop_active !== 1'b1) begin
            n_fail++;
            $display("FAIL reentry: err=%b iter=%0d active=%b, need 0010/2/1", err_flags, iter_count, loop_active);
        end
        step(4); step(5);
        n_checks++;
        if (rec_trip !== 32'd2 || rec_cycles !== 32'd5 || loop_entries !== 32'd1) begin
            n_fail++;
            $display("FAIL reentry_record: trip=%0d cyc=%0d entries=%0d, need 2/5/1", rec_trip, rec_cycles, loop_entries);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        rec_ready = 1'b0;
        step(1); step(2); step(3); step(4); step(2); step(3); step(4); step(5); step(0);
        step(1); step(2); step(4); step(2); step(4); step(2); step(4); step(5);
        n_checks++;
        if (err_flags !== 4'b1000 || rec_valid !== 1'b1 || rec_trip !== 32'd2 || rec_cycles !== 32'd6) begin
            n_fail++;
            $display("FAIL overflow_hold: err=%b rv=%b trip=%0d cyc=%0d, need 1000/1/2/6", err_flags, rec_valid, rec_trip, rec_cycles);
        end
        step(0); step(1); step(2); step(3); step(3); step(4);
        rec_ready = 1'b1;
        step(5);
        n_checks++;
        if (rec_valid !== 1'b1 || rec_trip !== 32'd1 || rec_cycles !== 32'd4 || loop_entries !== 32'd3) begin
            n_fail++;
            $display("FAIL drain_and_load: rv=%b trip=%0d cyc=%0d entries=%0d, need 1/1/4/3",
                     rec_valid, rec_trip, rec_cycles, loop_entries);
        end
    endtask

    task automatic test_finish_in_loop();
        apply_reset();
        step(1); step(2); step(3);
        finish = 1'b1;
        step(4);
        finish = 1'b0;
        n_checks++;
        if (err_flags !== 4'b0100 || done !== 1'b1 || loop_active !== 1'b0 || rec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL finish_active: err=%b done=%b active=%b rv=%b, need 0100/1/0/0", err_flags, done, loop_active, rec_valid);
        end
        step(0); step(1); step(2); step(3); step(4); step(5); step(0);
        n_checks++;
        if (loop_entries !== 32'd1 || loop_active !== 1'b0 || rec_valid !== 1'b0 || done !== 1'b1 || err_flags !== 4'b0100) begin
            n_fail++;
            $display("FAIL done_frozen: entries=%0d active=%b rv=%b done=%b err=%b, need 1/0/0/1/0100",
                     loop_entries, loop_active, rec_valid, done, err_flags);
        end
    endtask

    task automatic test_async_reset_mid_loop();
        apply_reset();
        step(1); step(2); step(3);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({loop_active, iter_count, loop_entries, rec_valid, err_flags, done} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: active=%b iter=%0d entries=%0d rv=%b err=%b done=%b, need all 0",
                     loop_active, iter_count, loop_entries, rec_valid, err_flags, done);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        step(4); step(1); step(2); step(3); step(4); step(2); step(4); step(5);
        n_checks++;
        if (rec_valid !== 1'b1 || rec_trip !== 32'd2 || rec_cycles !== 32'd5 || loop_entries !== 32'd1) begin
            n_fail++;
            $display("FAIL clean_after_reset: rv=%b trip=%0d cyc=%0d entries=%0d, need 1/2/5/1",
                     rec_valid, rec_trip, rec_cycles, loop_entries);
        end
    endtask

    // Expected values come from how each execution is generated: trip is the
    // number of iterations, cycles is the summed length of the iteration bodies.
    task automatic test_random_loops();
        int exp_entries;
        int exp_cycles;
        int n_iter;
        int n_mid;
        logic [2:0] gap_pool [3];
        gap_pool[0] = 3'd0; gap_pool[1] = 3'd6; gap_pool[2] = 3'd7;
        apply_reset();
        exp_entries = 0;
        for (int run = 0; run < 8; run++) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) step(gap_pool[$urandom_range(0, 2)]);
            step(1);
            n_iter = int'($urandom_range(1, 5));
            exp_cycles = 0;
            exp_entries++;
            for (int i = 1; i <= n_iter; i++) begin
                step(2);
                n_checks++;
                if (iter_count !== 32'(i) || loop_active !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rand_iter run%0d: iter=%0d active=%b, need %0d/1", run, iter_count, loop_active, i);
                end
                n_mid = int'($urandom_range(0, 3));
                for (int m = 0; m < n_mid; m++) step(3);
                step(4);
                exp_cycles += 2 + n_mid;
            end
            step(5);
            n_checks++;
            if (rec_valid !== 1'b1 || rec_trip !== 32'(n_iter) || rec_cycles !== 32'(exp_cycles) ||
                loop_entries !== 32'(exp_entries)) begin
                n_fail++;
                $display("FAIL rand_record run%0d: rv=%b trip=%0d cyc=%0d entries=%0d, need 1/%0d/%0d/%0d",
                         run, rec_valid, rec_trip, rec_cycles, loop_entries, n_iter, exp_cycles, exp_entries);
            end
            step(0);
        end
        n_checks++;
        if (err_flags !== 4'b0 || rec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_clean: err=%b rv=%b, need 0000/0", err_flags, rec_valid);
        end
    endtask

    initial begin
        reset = 1'b1;
        cur_state = 3'd0; finish = 1'b0; rec_ready = 1'b1;
        pre_states_valid = 1'b1; pre_loop_state0 = 3'd1;
        quit_states_valid = 2'b01; quit_loop_state0 = 3'd4; quit_loop_state1 = 3'd0;
        loop_quit_state = 3'd5; iter_start_state = 3'd2;
        one_state_loop = 1'b0; one_state_block = 1'b0;
        test_reset();
        test_basic_loop();
        test_one_state_loop();
        test_exit_without_entry();
        test_reentry();
        test_overflow();
        test_finish_in_loop();
        test_async_reset_mid_loop();
        test_random_loops();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
